bcd_timer_ctrl: RTL and testbench

Sequencing controller for a 3-digit BCD count chain (000–999). It generates the count-enable (carry-in) rate from a clock prescaler and accepts start/pause/clear commands. It compares the running count against a latched BCD target and reports completion, with optional auto-reload. It is the block that turns the raw cascaded BCD counter into a usable timer or event counter for display and control logic.

---
 rtl/bcd_timer_ctrl_if.sv | 16 +
 rtl/bcd_timer_ctrl.sv | 85 ++++++++
 tb/tb_bcd_timer_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_timer_ctrl_if.sv
// bcd_timer_ctrl_if: command, target and status bundle for the BCD timer controller.
interface bcd_timer_ctrl_if;
  logic        start;
  logic        pause;
  logic        clr;
  logic        reload;
  logic [11:0] target;
  logic [11:0] q;
  logic        tick;
  logic        cout;
  logic        done;
  logic        busy;
  logic        err;
  modport master (output start, pause, clr, reload, target, input q, tick, cout, done, busy, err);
  modport slave (input start, pause, clr, reload, target, output q, tick, cout, done, busy, err);
endinterface

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: prescaled 3-digit BCD count sequencer with start/pause/clear, target compare and auto-reload.
module bcd_timer_ctrl #(
  parameter int DIV = 4
) (
  input logic             clk,
  input logic             rst,
  bcd_timer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t      state_q, state_d;
  logic [11:0] q_q, q_d, tgt_q, tgt_d, inc;
  logic [15:0] pre_q, pre_d;
  logic        cout_q, cout_d, err_q, err_d;
  logic        tick, wrap, tgt_ok, o9, t9, h9;
  assign o9 = q_q[3:0] == 4'd9;
  assign t9 = q_q[7:4] == 4'd9;
  assign h9 = q_q[11:8] == 4'd9;
  assign wrap = o9 && t9 && h9;
  assign inc = {o9 && t9 ? (h9 ? 4'd0 : q_q[11:8] + 4'd1) : q_q[11:8],
                o9 ? (t9 ? 4'd0 : q_q[7:4] + 4'd1) : q_q[7:4],
                o9 ? 4'd0 : q_q[3:0] + 4'd1};
  assign tgt_ok = bus.target[11:8] <= 4'd9 && bus.target[7:4] <= 4'd9 && bus.target[3:0] <= 4'd9;
  assign tick = state_q == RUN && pre_q == 16'(DIV - 1);
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    pre_d = pre_q;
    tgt_d = tgt_q;
    cout_d = 1'b0;
    err_d = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      q_d = '0;
      pre_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && tgt_ok) begin
            state_d = RUN;
            tgt_d = bus.target;
            pre_d = '0;
          end
          err_d = bus.start && !tgt_ok;
        end
        RUN: begin
          pre_d = tick ? 16'd0 : pre_q + 16'd1;
          q_d = tick ? inc : q_q;
          cout_d = tick && wrap;
          // a landing on the target outranks a simultaneous pause
          state_d = tick && inc == tgt_q ? DONE : bus.pause ? PAUSE : RUN;
        end
        PAUSE: state_d = bus.start && !bus.pause ? RUN : PAUSE;
        DONE: begin
          state_d = bus.reload ? RUN : IDLE;
          q_d = bus.reload ? 12'd0 : q_q;
          pre_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      pre_q <= '0;
      tgt_q <= '0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      pre_q <= pre_d;
      tgt_q <= tgt_d;
      cout_q <= cout_d;
      err_q <= err_d;
    end
  end
  assign bus.q = q_q;
  assign bus.tick = tick;
  assign bus.cout = cout_q;
  assign bus.done = state_q == DONE;
  assign bus.busy = state_q == RUN || state_q == PAUSE;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed checks of three controller instances (DIV 4, 1, 2) sharing one clock and reset.
module tb_bcd_timer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bcd_timer_ctrl_if a4 ();
  bcd_timer_ctrl_if a1 ();
  bcd_timer_ctrl_if a2 ();
  bcd_timer_ctrl #(.DIV(4)) u4 (.clk(clk), .rst(rst), .bus(a4));
  bcd_timer_ctrl #(.DIV(1)) u1 (.clk(clk), .rst(rst), .bus(a1));
  bcd_timer_ctrl #(.DIV(2)) u2 (.clk(clk), .rst(rst), .bus(a2));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int done_at, cout_at, done_cnt, cout_cnt;
    bit got;
    {a4.start, a4.pause, a4.clr, a4.reload, a4.target} = '0;
    {a1.start, a1.pause, a1.clr, a1.reload, a1.target} = '0;
    {a2.start, a2.pause, a2.clr, a2.reload, a2.target} = '0;
    step(2);
    rst = 1'b0;
    chk("rst_q", a4.q, 12'h000);
    chk("rst_busy", a4.busy, 0);
    chk("rst_pulses", {a4.tick, a4.cout, a4.done, a4.err}, 4'b0000);
    // DIV=4 run to 012
    a4.target = 12'h012;
    a4.start = 1'b1;
    step(1);
    a4.start = 1'b0;
    chk("t1_busy", a4.busy, 1);
    chk("t1_tick0", a4.tick, 0);
    done_at = -1;
    done_cnt = 0;
    for (int i = 1; i <= 52; i++) begin
      step(1);
      if (a4.done) begin done_cnt++; if (done_at < 0) done_at = i; end
      if (i == 3) chk("t1_tick_e3", a4.tick, 1);
      if (i == 4) chk("t1_q_e4", a4.q, 12'h001);
      if (i == 40) chk("t1_q_e40", a4.q, 12'h010);
      if (i == 48) chk("t1_q_e48", a4.q, 12'h012);
    end
    chk("t1_done_at", done_at, 48);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_idle_q", a4.q, 12'h012);
    chk("t1_idle_busy", a4.busy, 0);
    // DIV=1 full wrap to target 000
    a1.target = 12'h000;
    a1.start = 1'b1;
    step(1);
    a1.start = 1'b0;
    done_at = -1; cout_at = -1; done_cnt = 0; cout_cnt = 0;
    for (int i = 1; i <= 1005; i++) begin
      step(1);
      if (a1.done) begin done_cnt++; if (done_at < 0) done_at = i; end
      if (a1.cout) begin cout_cnt++; if (cout_at < 0) cout_at = i; end
      if (i == 999) chk("t2_q_999", a1.q, 12'h999);
      if (i == 1000) chk("t2_done_cout", {a1.done, a1.cout}, 2'b11);
    end
    chk("t2_done_at", done_at, 1000);
    chk("t2_cout_at", cout_at, 1000);
    chk("t2_counts", {done_cnt[7:0], cout_cnt[7:0]}, 16'h0101);
    chk("t2_end", {a1.busy, a1.q}, 13'h0000);
    // pause of 10 cycles after the 2nd tick
    a4.clr = 1'b1;
    step(1);
    a4.clr = 1'b0;
    chk("t3_clr_q", a4.q, 12'h000);
    a4.target = 12'h005;
    a4.start = 1'b1;
    step(1);
    a4.start = 1'b0;
    step(8);
    chk("t3_q_e8", a4.q, 12'h002);
    a4.pause = 1'b1;
    a4.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t3_pause_state", {a4.busy, a4.tick, a4.q}, {2'b10, 12'h002});
    end
    a4.pause = 1'b0;
    step(1);
    a4.start = 1'b0;
    chk("t3_resume", {a4.busy, a4.q}, {1'b1, 12'h002});
    done_at = -1;
    for (int i = 20; i <= 40; i++) begin
      step(1);
      if (a4.done && done_at < 0) done_at = i;
    end
    chk("t3_done_at", done_at, 30);
    chk("t3_end_q", a4.q, 12'h005);
    // non-BCD target rejected, then run 005 -> 003 through the wrap
    a4.target = 12'h0A3;
    a4.start = 1'b1;
    step(1);
    a4.start = 1'b0;
    chk("t4_err", {a4.err, a4.busy, a4.q}, {2'b10, 12'h005});
    step(1);
    chk("t4_err_clear", {a4.err, a4.busy}, 2'b00);
    a4.target = 12'h003;
    a4.start = 1'b1;
    step(1);
    a4.start = 1'b0;
    chk("t4_err_none", a4.err, 0);
    done_at = -1; cout_at = -1;
    for (int i = 1; i <= 4000; i++) begin
      step(1);
      if (a4.done && done_at < 0) done_at = i;
      if (a4.cout && cout_at < 0) cout_at = i;
    end
    chk("t4_cout_at", cout_at, 3980);
    chk("t4_done_at", done_at, 3992);
    chk("t4_end_q", a4.q, 12'h003);
    // DIV=2 auto-reload
    a2.target = 12'h002;
    a2.reload = 1'b1;
    a2.start = 1'b1;
    step(1);
    a2.start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (a2.done) begin done_cnt++; chk("t5_done_phase", i % 5, 4); end
      if (i == 5) chk("t5_q_e5", a2.q, 12'h000);
      if (i == 7) chk("t5_q_e7", a2.q, 12'h001);
      if (i == 9) chk("t5_q_e9", a2.q, 12'h002);
    end
    chk("t5_done_cnt", done_cnt, 3);
    a2.reload = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step(1);
      got = a2.done;
    end
    chk("t5_final_done", got, 1);
    step(1);
    chk("t5_stop", {a2.busy, a2.q}, {1'b0, 12'h002});
    a2.clr = 1'b1;
    a2.start = 1'b1;
    step(1);
    a2.clr = 1'b0;
    a2.start = 1'b0;
    chk("t5_clr_start", {a2.busy, a2.q}, 13'h0000);
    step(2);
    chk("t5_clr_idle", a2.busy, 0);
    // reset mid-run at 057 with start held
    a4.clr = 1'b1;
    step(1);
    a4.clr = 1'b0;
    a4.target = 12'h100;
    a4.start = 1'b1;
    step(1);
    a4.start = 1'b0;
    step(228);
    chk("t6_q_057", {a4.busy, a4.q}, {1'b1, 12'h057});
    rst = 1'b1;
    a4.start = 1'b1;
    step(1);
    chk("t6_rst", {a4.busy, a4.q}, 13'h0000);
    chk("t6_rst_pulses", {a4.tick, a4.cout, a4.done, a4.err}, 4'b0000);
    rst = 1'b0;
    a4.start = 1'b0;
    step(2);
    chk("t6_idle", {a4.busy, a4.q}, 13'h0000);
    a4.start = 1'b1;
    step(1);
    a4.start = 1'b0;
    step(3);
    chk("t6_tick", {a4.busy, a4.tick}, 2'b11);
    step(1);
    chk("t6_q_001", a4.q, 12'h001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
